// File: rtl/imem_loader_pkg.sv
`default_nettype none
// imem_loader_pkg: state encoding and word geometry shared by the loader and its byte packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_STRIDE    = 4;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// byte_packer: gathers accepted bytes into a 32-bit word; word_complete flags the last byte of each word.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_complete
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt;
  logic [31:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 2'd0;
      shreg <= 32'd0;
    end else if (clear) begin
      cnt   <= 2'd0;
      shreg <= 32'd0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
      // Big-endian shifts toward the MSB so the first byte ends in [31:24].
      if (BIG_ENDIAN != 0) shreg <= {shreg[23:0], data};
      else                 shreg <= {data, shreg[31:8]};
    end
  end

  assign word          = shreg;
  assign word_complete = accept && (cnt == LAST_BYTE);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: streams a byte program into instruction memory as word writes, holding the CPU meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS  = 256,
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        abort,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        pc_restart,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state, next_state;
  logic [15:0] count;
  logic [15:0] word_index;
  logic        error_q;
  logic        err_from_load;
  logic [31:0] packed_word;
  logic        word_complete;
  logic        start_ok;
  logic        start_accept;
  logic        last_word;
  logic        byte_accept;

  assign start_ok     = (word_count != 16'd0) && ({16'd0, word_count} <= MAX_W);
  assign start_accept = (state == ST_IDLE) && start && start_ok;
  assign last_word    = (word_index == (count - 16'd1));
  assign byte_accept  = byte_valid && byte_ready;

  byte_packer #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (start_accept),
    .accept       (byte_accept),
    .data         (byte_data),
    .word         (packed_word),
    .word_complete(word_complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b0;
    pc_restart = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = start_ok ? ST_RECV : ST_ERR;
      end
      ST_RECV: begin
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        byte_ready = !abort;
        if (abort)              next_state = ST_ERR;
        else if (word_complete) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        // The write is committed even when abort lands on this cycle.
        busy     = 1'b1;
        cpu_hold = 1'b1;
        imem_we  = 1'b1;
        if (abort)          next_state = ST_ERR;
        else if (last_word) next_state = ST_DONE;
        else                next_state = ST_RECV;
      end
      ST_DONE: begin
        done       = 1'b1;
        pc_restart = 1'b1;
        cpu_hold   = 1'b1;
        next_state = ST_IDLE;
      end
      ST_ERR: begin
        cpu_hold   = err_from_load;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= 16'd0;
      word_index    <= 16'd0;
      error_q       <= 1'b0;
      err_from_load <= 1'b0;
    end else begin
      if (start_accept) begin
        count      <= word_count;
        word_index <= 16'd0;
        error_q    <= 1'b0;
      end else if ((state == ST_WRITE) && !abort && !last_word) begin
        word_index <= word_index + 16'd1;
      end
      if (next_state == ST_ERR) begin
        error_q       <= 1'b1;
        err_from_load <= (state != ST_IDLE);
      end
    end
  end

  assign error      = error_q;
  assign imem_addr  = (state == ST_WRITE) ? ({16'd0, word_index} * 32'(WORD_STRIDE)) : 32'd0;
  assign imem_wdata = (state == ST_WRITE) ? packed_word : 32'd0;

endmodule
`default_nettype wire
